// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: 2-flop sync, press/release debounce,
// one-cycle press strobe plus optional auto-repeat strobes while held.
// Ports: clk, reset (sync, active-high), btn_in[N_BTN] raw buttons (1 = pressed),
//        rep_en[N_BTN] repeat enable, btn_level[N_BTN] debounced level,
//        btn_pulse[N_BTN] one-cycle press/repeat strobe. All outputs registered.
module btn_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int HOLD_CYCLES     = 5_000_000,
    parameter int REPEAT_CYCLES   = 2_000_000,
    parameter int CNT_BIT         = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [N_BTN-1:0] rep_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    typedef enum logic [2:0] {
        IDLE,
        ARMING,
        HELD,
        REPEAT,
        RELEASING
    } state_t;

    // Terminal counts, sized to the counter so comparisons are width-exact.
    localparam logic [CNT_BIT-1:0] DEB_LAST  = CNT_BIT'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_BIT-1:0] HOLD_LAST = CNT_BIT'(HOLD_CYCLES - 1);
    localparam logic [CNT_BIT-1:0] REP_LAST  = CNT_BIT'(REPEAT_CYCLES - 1);
    localparam logic [CNT_BIT-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_BIT-1:0] CNT_ONE   = CNT_BIT'(1);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        logic                s0;
        logic                s1;
        logic                lvl;
        logic                pls;
        state_t              state;
        logic [CNT_BIT-1:0]  cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                s0    <= 1'b0;
                s1    <= 1'b0;
                state <= IDLE;
                cnt   <= CNT_ZERO;
                lvl   <= 1'b0;
                pls   <= 1'b0;
            end else begin
                s0  <= btn_in[i];
                s1  <= s0;
                // Strobe is single-cycle: cleared every cycle unless a
                // press or repeat point sets it below.
                pls <= 1'b0;

                case (state)
                    IDLE: begin
                        cnt <= CNT_ZERO;
                        if (s1) begin
                            state <= ARMING;
                            cnt   <= CNT_ONE;
                        end
                    end

                    ARMING: begin
                        if (!s1) begin
                            state <= IDLE;
                            cnt   <= CNT_ZERO;
                        end else if (cnt == DEB_LAST) begin
                            state <= HELD;
                            cnt   <= CNT_ZERO;
                            lvl   <= 1'b1;
                            pls   <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    HELD: begin
                        if (!s1) begin
                            state <= RELEASING;
                            cnt   <= CNT_ONE;
                        end else if (cnt == HOLD_LAST) begin
                            state <= REPEAT;
                            cnt   <= CNT_ZERO;
                            pls   <= rep_en[i];
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    REPEAT: begin
                        if (!s1) begin
                            state <= RELEASING;
                            cnt   <= CNT_ONE;
                        end else if (cnt == REP_LAST) begin
                            cnt <= CNT_ZERO;
                            pls <= rep_en[i];
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    RELEASING: begin
                        if (s1) begin
                            // Release bounce: back to HELD with a fresh hold
                            // timer and no strobe, it is not a new press.
                            state <= HELD;
                            cnt   <= CNT_ZERO;
                        end else if (cnt == DEB_LAST) begin
                            state <= IDLE;
                            cnt   <= CNT_ZERO;
                            lvl   <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        cnt   <= CNT_ZERO;
                        lvl   <= 1'b0;
                    end
                endcase
            end
        end

        assign btn_level[i] = lvl;
        assign btn_pulse[i] = pls;
    end

endmodule
